// File: rtl/mc_datapath_p.sv
// Multicycle MIPS-style datapath: PC, IR, MDR, ALUOut, register file, ALU
// and the operand/writeback muxes. It is driven by the multicycle control
// FSM and talks to memory/IO over the MIO bus. The width and register count
// are parameters. A memory-ready stall freezes all state. An overflow trap
// captures EPC/Cause and vectors the PC, and eret returns through EPC.
//
// Memory handshake: mem_access acts as the request "valid" and MIO_ready
// as "ready". An access completes on the first rising edge where both are
// high. While mem_access=1 and MIO_ready=0, stall is high and every state
// element (PC, IR, MDR, ALUOut, register file, EPC, cause, exc_status)
// holds. The controller must keep its control inputs stable until the
// access completes. There is no bound on how long a stall may last.
module mc_datapath_p #(
  parameter int               WIDTH      = 32,
  parameter int               NREG       = 32,
  parameter int               LINK_REG   = 31,
  parameter logic [WIDTH-1:0] RESET_PC   = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR = 'h180
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MIO_ready,
  input  logic             mem_access,
  input  logic             IorD,
  input  logic             IRWrite,
  input  logic [1:0]       RegDst,
  input  logic             RegWrite,
  input  logic [1:0]       MemtoReg,
  input  logic             ALUSrcA,
  input  logic [1:0]       ALUSrcB,
  input  logic [1:0]       PCSource,
  input  logic             PCWrite,
  input  logic             PCWriteCond,
  input  logic             Branch,
  input  logic [2:0]       ALU_operation,
  input  logic             trap_en,
  input  logic             eret,
  input  logic [31:0]      data2CPU,
  output logic [WIDTH-1:0] PC_Current,
  output logic [31:0]      Inst,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] M_addr,
  output logic             stall,
  output logic             zero,
  output logic             overflow,
  output logic             exc_status,
  output logic [WIDTH-1:0] epc,
  output logic [1:0]       cause
);

  localparam int         IDXW     = $clog2(NREG);
  localparam logic [5:0] NREG6    = 6'(NREG);
  localparam logic [4:0] LINK_IDX = 5'(LINK_REG);

  logic [WIDTH-1:0] pc_q, alu_out_q, mdr_q, epc_q;
  logic [31:0]      ir_q;
  logic [1:0]       cause_q;
  logic             exc_q;
  logic [WIDTH-1:0] regs [NREG];

  logic [4:0]       ra_idx, rb_idx, wr_idx;
  logic [WIDTH-1:0] rdata_a, rdata_b, wdata;
  logic [WIDTH-1:0] imm, lui_val, jump_tgt;
  logic [WIDTH-1:0] alu_a, alu_b, res, pc_next;
  logic             pc_we, trap, reg_we;

  assign ra_idx = ir_q[25:21];
  assign rb_idx = ir_q[20:16];

  assign imm      = WIDTH'($signed(ir_q[15:0]));
  assign lui_val  = WIDTH'($signed({ir_q[15:0], 16'h0000}));
  assign jump_tgt = {pc_q[WIDTH-1:28], ir_q[25:0], 2'b00};

  // Asynchronous read ports; r0 and indices beyond NREG read as zero
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    if (ra_idx != 5'd0 && {1'b0, ra_idx} < NREG6) rdata_a = regs[ra_idx[IDXW-1:0]];
    if (rb_idx != 5'd0 && {1'b0, rb_idx} < NREG6) rdata_b = regs[rb_idx[IDXW-1:0]];
  end

  // ALU operand selection
  always_comb begin
    alu_a = ALUSrcA ? rdata_a : pc_q;
    case (ALUSrcB)
      2'b00:   alu_b = rdata_b;
      2'b01:   alu_b = WIDTH'(4);
      2'b10:   alu_b = imm;
      default: alu_b = {imm[WIDTH-3:0], 2'b00};
    endcase
  end

  // ALU result and signed overflow (only add/sub can overflow)
  always_comb begin
    overflow = 1'b0;
    case (ALU_operation)
      3'b000: res = alu_a & alu_b;
      3'b001: res = alu_a | alu_b;
      3'b010: begin
        res      = alu_a + alu_b;
        overflow = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (res[WIDTH-1] != alu_a[WIDTH-1]);
      end
      3'b011: res = alu_a ^ alu_b;
      3'b100: res = ~(alu_a | alu_b);
      3'b101: res = alu_b >> ir_q[10:6];
      3'b110: begin
        res      = alu_a - alu_b;
        overflow = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (res[WIDTH-1] != alu_a[WIDTH-1]);
      end
      default: res = WIDTH'($signed(alu_a) < $signed(alu_b));
    endcase
  end

  // Writeback register/data selection and the write enable
  always_comb begin
    case (RegDst)
      2'b00:   wr_idx = ir_q[20:16];
      2'b01:   wr_idx = ir_q[15:11];
      default: wr_idx = LINK_IDX;
    endcase
    case (MemtoReg)
      2'b00:   wdata = alu_out_q;
      2'b01:   wdata = mdr_q;
      2'b10:   wdata = lui_val;
      default: wdata = res;
    endcase
    reg_we = RegWrite && !stall && !trap && wr_idx != 5'd0 && {1'b0, wr_idx} < NREG6;
  end

  // Next-PC source mux
  always_comb begin
    case (PCSource)
      2'b00:   pc_next = res;
      2'b01:   pc_next = alu_out_q;
      2'b10:   pc_next = jump_tgt;
      default: pc_next = rdata_a;
    endcase
  end

  assign stall = mem_access & ~MIO_ready;
  assign zero  = (res == '0);
  assign trap  = trap_en & overflow & ~stall;
  assign pc_we = ~stall & (PCWrite | (PCWriteCond & (zero == Branch)));

  // Architectural state: trap beats eret beats a normal PC write, and a stall freezes everything
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      mdr_q     <= '0;
      alu_out_q <= '0;
      epc_q     <= '0;
      cause_q   <= '0;
      exc_q     <= 1'b0;
    end else if (!stall) begin
      mdr_q     <= WIDTH'(data2CPU);
      alu_out_q <= res;
      if (IRWrite) ir_q <= data2CPU;
      if (trap) begin
        pc_q    <= EXC_VECTOR;
        if (!exc_q) epc_q <= pc_q;
        cause_q <= 2'd1;
        exc_q   <= 1'b1;
      end else if (eret) begin
        pc_q    <= epc_q;
        cause_q <= 2'd0;
        exc_q   <= 1'b0;
      end else if (pc_we) begin
        pc_q    <= pc_next;
      end
    end
  end

  // Register file write port; a same-cycle read still sees the old value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (reg_we) begin
      regs[wr_idx[IDXW-1:0]] <= wdata;
    end
  end

  assign PC_Current = pc_q;
  assign Inst       = ir_q;
  assign data_out   = rdata_b;
  assign M_addr     = IorD ? alu_out_q : pc_q;
  assign exc_status = exc_q;
  assign epc        = epc_q;
  assign cause      = cause_q;

endmodule

// File: tb/tb_mc_datapath_p.sv
// Directed bench for mc_datapath_p. The default 32-bit/32-register instance
// and a 64-bit/16-register instance share the same control stimulus.
module tb_mc_datapath_p;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, mio_ready, mem_access, iord, irwrite, regwrite;
  logic        alusrca, pcwrite, pcwritecond, branch, trap_en, eret;
  logic [1:0]  regdst, memtoreg, alusrcb, pcsource;
  logic [2:0]  alu_op;
  logic [31:0] data2cpu;

  logic [31:0] pc_cur, inst, data_out, m_addr, epc;
  logic        stall, zero, overflow, exc_status;
  logic [1:0]  cause;

  logic [63:0] pc_cur_w, data_out_w, m_addr_w, epc_w;
  logic [31:0] inst_w;
  logic        stall_w, zero_w, overflow_w, exc_status_w;
  logic [1:0]  cause_w;

  mc_datapath_p u_dut (
    .clk(clk), .reset(reset), .MIO_ready(mio_ready), .mem_access(mem_access),
    .IorD(iord), .IRWrite(irwrite), .RegDst(regdst), .RegWrite(regwrite),
    .MemtoReg(memtoreg), .ALUSrcA(alusrca), .ALUSrcB(alusrcb), .PCSource(pcsource),
    .PCWrite(pcwrite), .PCWriteCond(pcwritecond), .Branch(branch),
    .ALU_operation(alu_op), .trap_en(trap_en), .eret(eret), .data2CPU(data2cpu),
    .PC_Current(pc_cur), .Inst(inst), .data_out(data_out), .M_addr(m_addr),
    .stall(stall), .zero(zero), .overflow(overflow), .exc_status(exc_status),
    .epc(epc), .cause(cause)
  );

  mc_datapath_p #(.WIDTH(64), .NREG(16)) u_dut64 (
    .clk(clk), .reset(reset), .MIO_ready(mio_ready), .mem_access(mem_access),
    .IorD(iord), .IRWrite(irwrite), .RegDst(regdst), .RegWrite(regwrite),
    .MemtoReg(memtoreg), .ALUSrcA(alusrca), .ALUSrcB(alusrcb), .PCSource(pcsource),
    .PCWrite(pcwrite), .PCWriteCond(pcwritecond), .Branch(branch),
    .ALU_operation(alu_op), .trap_en(trap_en), .eret(eret), .data2CPU(data2cpu),
    .PC_Current(pc_cur_w), .Inst(inst_w), .data_out(data_out_w), .M_addr(m_addr_w),
    .stall(stall_w), .zero(zero_w), .overflow(overflow_w), .exc_status(exc_status_w),
    .epc(epc_w), .cause(cause_w)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mio_ready = 1'b1; mem_access = 1'b0; iord = 1'b0; irwrite = 1'b0;
    regdst = 2'b00; regwrite = 1'b0; memtoreg = 2'b00; alusrca = 1'b0;
    alusrcb = 2'b00; pcsource = 2'b00; pcwrite = 1'b0; pcwritecond = 1'b0;
    branch = 1'b0; alu_op = 3'b000; trap_en = 1'b0; eret = 1'b0;
  endtask

  task automatic load_ir(input logic [31:0] word);
    irwrite = 1'b1; data2cpu = word;
    step();
    irwrite = 1'b0;
  endtask

  // Loads IR with rt=r, lets MDR capture v, then writes MDR into rt.
  task automatic write_reg(input logic [4:0] r, input logic [31:0] v);
    load_ir({11'b0, r, 16'h0000});
    data2cpu = v;
    step();
    regdst = 2'b00; memtoreg = 2'b01; regwrite = 1'b1;
    step();
    idle();
  endtask

  task automatic pc_plus4();
    idle();
    alusrca = 1'b0; alusrcb = 2'b01; alu_op = 3'b010; pcsource = 2'b00; pcwrite = 1'b1;
    step();
    idle();
  endtask

  // Overflowing add (IR rs=5, rt=6, rd=7) with trap enabled and register/PC writes requested
  task automatic arm_trap();
    alusrca = 1'b1; alusrcb = 2'b00; alu_op = 3'b010; trap_en = 1'b1;
    regdst = 2'b01; memtoreg = 2'b11; regwrite = 1'b1; pcwrite = 1'b1; pcsource = 2'b00;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [31:0] res;
    logic        zero;
    logic        ovf;
  } alu_vec_t;

  alu_vec_t vecs[12];

  initial begin
    vecs[0]  = '{"and",      3'b000, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0, 32'h00F0_1200, 1'b0, 1'b0};
    vecs[1]  = '{"or",       3'b001, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0, 32'hFFF0_FF34, 1'b0, 1'b0};
    vecs[2]  = '{"add",      3'b010, 32'd5,         32'd7,         5'd0, 32'd12,        1'b0, 1'b0};
    vecs[3]  = '{"add_ovf",  3'b010, 32'h7FFF_FFFF, 32'd1,         5'd0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[4]  = '{"add_wrap", 3'b010, 32'hFFFF_FFFF, 32'd1,         5'd0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[5]  = '{"xor",      3'b011, 32'hAAAA_5555, 32'hFFFF_0000, 5'd0, 32'h5555_5555, 1'b0, 1'b0};
    vecs[6]  = '{"nor",      3'b100, 32'hF0F0_0000, 32'h0F0F_0000, 5'd0, 32'h0000_FFFF, 1'b0, 1'b0};
    vecs[7]  = '{"srl",      3'b101, 32'd1,         32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0, 1'b0};
    vecs[8]  = '{"sub_eq",   3'b110, 32'd9,         32'd9,         5'd0, 32'd0,         1'b1, 1'b0};
    vecs[9]  = '{"sub_ovf",  3'b110, 32'h8000_0000, 32'd1,         5'd0, 32'h7FFF_FFFF, 1'b0, 1'b1};
    vecs[10] = '{"slt_neg",  3'b111, 32'hFFFF_FFFF, 32'd1,         5'd0, 32'd1,         1'b0, 1'b0};
    vecs[11] = '{"slt_pos",  3'b111, 32'd1,         32'hFFFF_FFFF, 5'd0, 32'd0,         1'b1, 1'b0};
  end

  // ---------------- test sequence ----------------
  initial begin
    idle();
    data2cpu = 32'h0;
    reset = 1'b0;
    #2;
    chk("rst_pc", pc_cur, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_cause", cause, 2'd0);
    chk("rst_exc", exc_status, 1'b0);
    chk("rst_pc_w", pc_cur_w, 64'h0);
    step();
    reset = 1'b1;
    step();

    // First IR load
    load_ir(32'h2008_0005);
    chk("ir_load", inst, 32'h2008_0005);

    // PC+4 fetch held off by three not-ready cycles
    idle();
    mem_access = 1'b1; mio_ready = 1'b0; irwrite = 1'b1; data2cpu = 32'h1234_5678;
    alusrca = 1'b0; alusrcb = 2'b01; alu_op = 3'b010; pcsource = 2'b00; pcwrite = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_hi", stall, 1'b1);
      step();
      chk("stall_pc", pc_cur, 32'h0);
      chk("stall_ir", inst, 32'h2008_0005);
    end
    mio_ready = 1'b1;
    #1;
    chk("stall_lo", stall, 1'b0);
    chk("fetch_addr", m_addr, 32'h0);
    step();
    chk("fetch_pc", pc_cur, 32'h4);
    chk("fetch_ir", inst, 32'h1234_5678);
    idle();

    // ALU table (PC stays at 4 throughout)
    for (int i = 0; i < 12; i++) begin
      write_reg(5'd1, vecs[i].a);
      write_reg(5'd2, vecs[i].b);
      load_ir({6'b0, 5'd1, 5'd2, 5'd0, vecs[i].shamt, 6'b0});
      alusrca = 1'b1; alusrcb = 2'b00; alu_op = vecs[i].op;
      #1;
      chk({vecs[i].name, "_zero"}, zero, vecs[i].zero);
      chk({vecs[i].name, "_ovf"}, overflow, vecs[i].ovf);
      step();
      iord = 1'b1;
      #1;
      chk({vecs[i].name, "_res"}, m_addr, vecs[i].res);
      idle();
    end

    // Register 0 is hard-wired; register 20 exists only in the 32-register build
    write_reg(5'd0, 32'hDEAD_BEEF);
    load_ir({11'b0, 5'd0, 16'h0});
    #1;
    chk("r0_read", data_out, 32'h0);
    write_reg(5'd20, 32'h1357_2468);
    load_ir({11'b0, 5'd20, 16'h0});
    #1;
    chk("r20_read", data_out, 32'h1357_2468);
    chk("r20_nreg16", data_out_w, 64'h0);

    // Branch: target = PC + (0x10 << 2), taken when zero == Branch
    write_reg(5'd3, 32'h55);
    write_reg(5'd4, 32'h55);
    load_ir({6'b0, 5'd3, 5'd4, 16'h0010});
    alusrca = 1'b0; alusrcb = 2'b11; alu_op = 3'b010;
    step();
    alusrca = 1'b1; alusrcb = 2'b00; alu_op = 3'b110;
    pcwritecond = 1'b1; branch = 1'b1; pcsource = 2'b01;
    #1;
    chk("br_zero", zero, 1'b1);
    step();
    chk("br_taken", pc_cur, 32'h44);
    idle();
    alusrca = 1'b0; alusrcb = 2'b11; alu_op = 3'b010;
    step();
    alusrca = 1'b1; alusrcb = 2'b00; alu_op = 3'b110;
    pcwritecond = 1'b1; branch = 1'b0; pcsource = 2'b01;
    step();
    chk("br_not_taken", pc_cur, 32'h44);
    idle();

    // Jump to 0x40
    load_ir(32'h0000_0010);
    pcwrite = 1'b1; pcsource = 2'b10;
    step();
    chk("jump_pc", pc_cur, 32'h40);
    idle();

    // Overflow trap from PC 0x40
    write_reg(5'd5, 32'h7FFF_FFFF);
    write_reg(5'd6, 32'h1);
    load_ir({6'b0, 5'd5, 5'd6, 5'd7, 11'b0});
    arm_trap();
    #1;
    chk("trap_ovf", overflow, 1'b1);
    step();
    chk("trap_pc", pc_cur, 32'h180);
    chk("trap_epc", epc, 32'h40);
    chk("trap_cause", cause, 2'd1);
    chk("trap_exc", exc_status, 1'b1);
    idle();
    load_ir({11'b0, 5'd7, 16'h0});
    #1;
    chk("trap_no_wb", data_out, 32'h0);

    // Nested trap leaves EPC alone
    load_ir({6'b0, 5'd5, 5'd6, 5'd7, 11'b0});
    pc_plus4();
    chk("exc_pc4", pc_cur, 32'h184);
    arm_trap();
    step();
    chk("nest_pc", pc_cur, 32'h180);
    chk("nest_epc", epc, 32'h40);

    // Trap under stall changes nothing
    pc_plus4();
    arm_trap();
    mem_access = 1'b1; mio_ready = 1'b0;
    #1;
    chk("trap_stall_hi", stall, 1'b1);
    step();
    chk("trap_stall_pc", pc_cur, 32'h184);
    chk("trap_stall_epc", epc, 32'h40);
    idle();

    // Trap wins over a simultaneous eret
    arm_trap();
    eret = 1'b1;
    step();
    chk("prio_pc", pc_cur, 32'h180);
    chk("prio_exc", exc_status, 1'b1);
    idle();

    // Eret returns to EPC
    eret = 1'b1;
    step();
    chk("eret_pc", pc_cur, 32'h40);
    chk("eret_exc", exc_status, 1'b0);
    chk("eret_cause", cause, 2'd0);
    idle();

    // lui 0x8000 into r8
    load_ir({11'b0, 5'd8, 16'h8000});
    regdst = 2'b00; memtoreg = 2'b10; regwrite = 1'b1;
    step();
    idle();
    #1;
    chk("lui32", data_out, 32'h8000_0000);
    chk("lui64", data_out_w, 64'hFFFF_FFFF_8000_0000);

    // r9 = nor(r0, r0) = -1, r10 = 1, then slt r9, r10
    load_ir({6'b0, 5'd0, 5'd0, 5'd9, 11'b0});
    alusrca = 1'b1; alusrcb = 2'b00; alu_op = 3'b100;
    regdst = 2'b01; memtoreg = 2'b11; regwrite = 1'b1;
    step();
    idle();
    write_reg(5'd10, 32'h1);
    load_ir({6'b0, 5'd9, 5'd10, 16'h0});
    alusrca = 1'b1; alusrcb = 2'b00; alu_op = 3'b111;
    step();
    iord = 1'b1;
    #1;
    chk("slt64", m_addr_w, 64'h1);
    chk("slt32", m_addr, 32'h1);
    idle();

    // Reset asserted in the middle of a stall acts without a clock edge
    mem_access = 1'b1; mio_ready = 1'b0; pcwrite = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("rst_stall_pc", pc_cur, 32'h0);
    chk("rst_stall_inst", inst, 32'h0);
    chk("rst_stall_epc", epc, 32'h0);
    step();
    reset = 1'b1;
    pc_plus4();
    chk("rst_restart_pc", pc_cur, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
